decoder_bin2hot_stream: RTL
===========================

// Module: decoder_bin2hot_stream
// PURPOSE
//  Streaming binary-to-one-hot decoder; inverse of the team's one-hot-to-binary encoders.
//  Accepts an IN_W-bit code on a valid/ready input and emits OUT_W one-hot bits on a valid/ready output.
//  Registered, 1-cycle latency, full throughput; a 2-entry skid buffer absorbs backpressure.
//  Sits between control logic that produces codes and the select/enable fabric they drive.
// PARAMETERS
//  IN_W   2       width of binary input code
//  OUT_W  4       one-hot output width; legal range 2..2**IN_W
// PORTS
//  clk        in   1      single clock; all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      in_code is valid this cycle
//  in_ready   out  1      block can accept a code this cycle
//  in_code    in   IN_W   binary code to decode
//  out_valid  out  1      out_hot holds a decoded beat
//  out_ready  in   1      downstream accepts the beat this cycle
//  out_hot    out  OUT_W  one-hot result; bit in_code set
//  out_err    out  1      [DEC_ERR_EN only] beat carried out-of-range code
//  err_sticky out  1      [DEC_ERR_EN only] any out-of-range code accepted since reset/clear
//  err_clr    in   1      [DEC_ERR_EN only] synchronous clear of err_sticky
// BEHAVIOUR
//  - Reset (async assert, sync deassert handled upstream): out_valid=0, out_hot=0, in_ready=1,
//    skid empty, out_err=0, err_sticky=0. Reset mid-stream discards both entries; no beat replayed.
//  - Input transfer: in_valid && in_ready on a rising edge. Output transfer: out_valid && out_ready.
//  - Decode: out_hot[i] = (in_code == i) for i < OUT_W; codes >= OUT_W decode to all zeros.
//  - Latency: code accepted at edge N appears on out_hot/out_valid after edge N (visible cycle N+1).
//  - Storage: main reg (drives outputs) + skid reg. in_ready = !skid_valid, driven from a flop.
//  - Main empty or draining: accepted beat loads main; skid stays empty; 1 beat/cycle sustained.
//  - Main full and not draining: accepted beat goes to skid; in_ready drops next cycle.
//  - Main drains with skid full: skid moves to main, in_ready returns high next cycle.
//  - Simultaneous accept and drain with skid empty: new beat replaces main the same edge.
//  - out_hot/out_valid (and out_err) hold stable while out_valid && !out_ready (AXI-style rule).
//  - in_valid while in_ready=0: ignored; source must hold the code. No beat lost or duplicated.
//  - out_hot is exactly one-hot or all-zero; never multi-hot. out_hot=0 whenever out_valid=0.
// CONFIGURATION
//  Macro DECODER_BIN2HOT_ERR_EN:
//  - Defined: out_err travels with each beat (1 when code >= OUT_W); err_sticky sets on accept of
//    such a code, clears on err_clr; set wins if accept and err_clr coincide.
//  - Undefined: out_err, err_sticky, err_clr ports absent; out-of-range codes silently give zero.
//  - When OUT_W == 2**IN_W the error path is constant 0 in either build.
// STRUCTURE
//  - Package decoder_pkg: function onehot_dec(code, width); beat struct {hot, err} typedef.
//  - Sub-module decoder_skid_buf: generic 2-entry valid/ready skid buffer, payload width param;
//    top instantiates it with payload = {err, hot}; decode is combinational before the buffer.
// TESTING
//  - Reset: hold rst_n=0 -> out_valid=0, out_hot=4'b0000, in_ready=1; assert rst_n async mid-cycle.
//  - Single beat: code 2, out_ready=1 -> next cycle out_valid=1, out_hot=4'b0100, then idle 0.
//  - Streaming: codes 0,1,2,3 back-to-back, out_ready=1 -> 0001,0010,0100,1000 on consecutive cycles.
//  - Backpressure: out_ready=0 for 3 cycles during stream -> in_ready low after 2 beats held,
//    out_hot stable, all 4 beats delivered in order once out_ready=1.
//  - Out-of-range (OUT_W=3, IN_W=2, macro on): code 3 -> out_hot=3'b000, out_err=1, err_sticky=1
//    until err_clr pulse; macro off -> out_hot=000, no err ports.
//  - Reset mid-stream with skid full -> both entries dropped, first post-reset beat decodes correctly.

Source files
------------

// File: rtl/decoder_bin2hot_stream_pkg.sv
// Shared types and decode helper for decoder_bin2hot_stream.
// The beat struct is sized for the widest supported output; users slice to OUT_W.
package decoder_pkg;

    localparam int unsigned MAX_OUT_W  = 32;
    localparam int unsigned MAX_CODE_W = $clog2(MAX_OUT_W);

    typedef struct packed {
        logic                 err;
        logic [MAX_OUT_W-1:0] hot;
    } beat_t;

    // Codes at or beyond width decode to all zeros and flag err.
    function automatic beat_t onehot_dec(logic [31:0] code, int unsigned width);
        beat_t b;
        b.hot = '0;
        b.err = (code >= width);
        if (!b.err) begin
            b.hot[code[MAX_CODE_W-1:0]] = 1'b1;
        end
        return b;
    endfunction

endpackage

// File: rtl/decoder_bin2hot_stream_if.sv
// Valid/ready bus for decoder_bin2hot_stream.
// Error signals exist only when DECODER_BIN2HOT_ERR_EN is defined.
interface decoder_bin2hot_stream_if #(
    parameter int unsigned IN_W  = 2,
    parameter int unsigned OUT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_code;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_hot;
`ifdef DECODER_BIN2HOT_ERR_EN
    logic             out_err;
    logic             err_sticky;
    logic             err_clr;

    modport master (
        output in_valid, in_code, out_ready, err_clr,
        input  in_ready, out_valid, out_hot, out_err, err_sticky
    );
    modport slave (
        input  in_valid, in_code, out_ready, err_clr,
        output in_ready, out_valid, out_hot, out_err, err_sticky
    );
`else
    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_hot
    );
    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_hot
    );
`endif
endinterface

// File: rtl/decoder_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: main register drives the outputs,
// skid register catches one beat when main is stalled. in_ready comes straight from a flop.
module decoder_skid_buf #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);
    logic             main_valid_d, main_valid_q;
    logic             skid_valid_d, skid_valid_q;
    logic [WIDTH-1:0] main_data_d, main_data_q;
    logic [WIDTH-1:0] skid_data_d, skid_data_q;
    logic             in_xfer;
    logic             main_free;

    always_comb begin
        in_xfer      = in_valid_i && !skid_valid_q;
        main_free    = !main_valid_q || out_ready_i;
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (main_free) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
                skid_data_d  = '0;
            end else if (in_xfer) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data_i;
            end else begin
                // Zero the payload so an idle output never shows a stale beat.
                main_valid_d = 1'b0;
                main_data_d  = '0;
            end
        end else if (in_xfer) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready_o  = !skid_valid_q;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;

endmodule

// File: rtl/decoder_bin2hot_stream.sv
// Streaming binary-to-one-hot decoder with 1-cycle latency and a 2-entry skid buffer.
// Define DECODER_BIN2HOT_ERR_EN to carry an out-of-range flag per beat plus a sticky error.
module decoder_bin2hot_stream
    import decoder_pkg::*;
#(
    parameter int unsigned IN_W  = 2,
    parameter int unsigned OUT_W = 4
) (
    input logic                     clk,
    input logic                     rst_n,
    decoder_bin2hot_stream_if.slave bus
);
    beat_t dec;
    logic  unused_dec_bits;

    always_comb begin
        dec = onehot_dec(32'(bus.in_code), OUT_W);
    end

    // Only dec.hot[OUT_W-1:0] (and err when enabled) are meaningful.
    assign unused_dec_bits = ^dec;

`ifdef DECODER_BIN2HOT_ERR_EN
    localparam int unsigned PAYLOAD_W = OUT_W + 1;
`else
    localparam int unsigned PAYLOAD_W = OUT_W;
`endif

    logic [PAYLOAD_W-1:0] in_data;
    logic [PAYLOAD_W-1:0] out_data;

`ifdef DECODER_BIN2HOT_ERR_EN
    assign in_data = {dec.err, dec.hot[OUT_W-1:0]};
`else
    assign in_data = dec.hot[OUT_W-1:0];
`endif

    decoder_skid_buf #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (bus.in_valid),
        .in_ready_o  (bus.in_ready),
        .in_data_i   (in_data),
        .out_valid_o (bus.out_valid),
        .out_ready_i (bus.out_ready),
        .out_data_o  (out_data)
    );

    assign bus.out_hot = out_data[OUT_W-1:0];

`ifdef DECODER_BIN2HOT_ERR_EN
    logic err_sticky_d, err_sticky_q;

    assign bus.out_err = out_data[OUT_W];

    // Set has priority over clear when both happen on the same edge.
    always_comb begin
        err_sticky_d = err_sticky_q;
        if (bus.err_clr) begin
            err_sticky_d = 1'b0;
        end
        if (bus.in_valid && bus.in_ready && dec.err) begin
            err_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky_q <= 1'b0;
        end else begin
            err_sticky_q <= err_sticky_d;
        end
    end

    assign bus.err_sticky = err_sticky_q;
`endif

endmodule
